game_sequencer: RTL and testbench

Parametrised run-control and pacing engine for grid games. It replaces the single running flag and fixed-period tick with a four-state game FSM, a programmable step divider that speeds up as the score grows, a saturating score/level counter, and seed capture for food placement. It sits between key_control and snake_field: it consumes start/pause/food/collision events and emits the step strobe, game state, score and level.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/game_sequencer_tick_divider.sv | 27 ++
 rtl/game_sequencer.sv | 114 +++++++++++
 tb/tb_game_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state encodings and pacing arithmetic for the game run-control engine.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   // Step period for a level, floored at the minimum; 64-bit so it never underflows.
   function automatic logic [63:0] period_of(
      input logic [63:0] lvl,
      input logic [63:0] base,
      input logic [63:0] min_clk,
      input logic [63:0] stp
   );
      logic [63:0] red;
      red = lvl * stp;
      if (red + min_clk >= base)
         return min_clk;
      return base - red;
   endfunction

   function automatic logic [63:0] max_level(
      input logic [63:0] base,
      input logic [63:0] min_clk,
      input logic [63:0] stp,
      input int          lw
   );
      logic [63:0] cap;
      logic [63:0] lim;
      cap = (64'd1 << lw) - 64'd1;
      if (base <= min_clk)
         lim = '0;
      else if (stp == '0)
         lim = cap;
      else
         lim = (base - min_clk) / stp;
      return (lim > cap) ? cap : lim;
   endfunction

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Programmable modulus counter; the >= terminal test keeps it safe when the
// period shrinks below the current count.
module tick_divider #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] period,
   output logic             tick
);

   logic [WIDTH-1:0] cnt;
   logic             term;

   assign term = ({1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1}) >= {1'b0, period};
   assign tick = en & ~clr & term;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= term ? '0 : cnt + WIDTH'(1);
   end

endmodule

// File: rtl/game_sequencer.sv
// Run-control FSM, level-paced step divider, saturating score/level and
// seed capture for food placement.
module game_sequencer #(
   parameter int TICK_BASE_CLK    = 12000000,
   parameter int TICK_MIN_CLK     = 3000000,
   parameter int SPEED_STEP_CLK   = 1000000,
   parameter int POINTS_PER_LEVEL = 5,
   parameter int SCORE_WIDTH      = 10,
   parameter int LEVEL_WIDTH      = 4,
   parameter int RAND_WIDTH       = $clog2(TICK_BASE_CLK)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   pause,
   input  logic                   food_eaten,
   input  logic                   collision,
   output logic                   step,
   output logic [1:0]             state,
   output logic [SCORE_WIDTH-1:0] score,
   output logic [LEVEL_WIDTH-1:0] level,
   output logic [RAND_WIDTH-1:0]  seed
);

   import game_pkg::*;

   localparam int PW  = $clog2(TICK_BASE_CLK + 1);
   localparam int PLW = (POINTS_PER_LEVEL > 1) ? $clog2(POINTS_PER_LEVEL) : 1;

   localparam logic [LEVEL_WIDTH-1:0] MAX_LEVEL = LEVEL_WIDTH'(max_level(
      64'(TICK_BASE_CLK), 64'(TICK_MIN_CLK), 64'(SPEED_STEP_CLK), LEVEL_WIDTH));

   localparam logic [PLW-1:0] PL_LAST = PLW'(POINTS_PER_LEVEL - 1);
   localparam logic [RAND_WIDTH-1:0] RND_LAST = RAND_WIDTH'(TICK_BASE_CLK - 1);

   state_t          st;
   logic            run;
   logic            tick;
   logic [PW-1:0]   period;
   logic [PLW-1:0]  plvl;
   logic [RAND_WIDTH-1:0] rnd;

   assign run   = (st == ST_RUN);
   assign state = st;

   assign period = PW'(period_of(64'(level), 64'(TICK_BASE_CLK),
                                 64'(TICK_MIN_CLK), 64'(SPEED_STEP_CLK)));

   tick_divider #(
      .WIDTH(PW)
   ) u_div (
      .clk    (clk),
      .rst    (rst),
      .en     (run),
      .clr    (start),
      .period (period),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (rst)
         rnd <= '0;
      else
         rnd <= (rnd == RND_LAST) ? '0 : rnd + RAND_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= ST_IDLE;
         step  <= 1'b0;
         score <= '0;
         level <= '0;
         plvl  <= '0;
         seed  <= '0;
      end else begin
         // No strobe on any edge that leaves RUN or restarts the game.
         step <= tick & ~start & ~collision & ~pause;
         if (start) begin
            st    <= ST_RUN;
            score <= '0;
            level <= '0;
            plvl  <= '0;
            seed  <= rnd;
         end else begin
            unique case (st)
               ST_RUN: begin
                  if (collision) begin
                     st <= ST_OVER;
                  end else if (pause) begin
                     st <= ST_PAUSE;
                  end else if (food_eaten) begin
                     seed <= rnd;
                     if (score != '1)
                        score <= score + SCORE_WIDTH'(1);
                     if (plvl == PL_LAST) begin
                        plvl <= '0;
                        if (level < MAX_LEVEL)
                           level <= level + LEVEL_WIDTH'(1);
                     end else begin
                        plvl <= plvl + PLW'(1);
                     end
                  end
               end
               ST_PAUSE: begin
                  if (pause)
                     st <= ST_RUN;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: step-time scoreboard plus
// table-driven event vectors.
module tb_game_sequencer;

   localparam int BASE = 10;
   localparam int MINP = 4;
   localparam int SPD  = 2;
   localparam int PPL  = 2;
   localparam int SW   = 4;
   localparam int LW   = 4;
   localparam int RW   = $clog2(BASE);

   logic clk = 1'b0;
   logic rst, start, pause, food_eaten, collision;
   logic          step;
   logic [1:0]    state;
   logic [SW-1:0] score;
   logic [LW-1:0] level;
   logic [RW-1:0] seed;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int rnd_m  = 0;
   int exp_q[$];

   typedef struct {
      logic s, p, f, c;
      int   st, sc, lv;
      bit   sd;
   } vec_t;

   vec_t tbl[15];

   game_sequencer #(
      .TICK_BASE_CLK    (BASE),
      .TICK_MIN_CLK     (MINP),
      .SPEED_STEP_CLK   (SPD),
      .POINTS_PER_LEVEL (PPL),
      .SCORE_WIDTH      (SW),
      .LEVEL_WIDTH      (LW),
      .RAND_WIDTH       (RW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pause      (pause),
      .food_eaten (food_eaten),
      .collision  (collision),
      .step       (step),
      .state      (state),
      .score      (score),
      .level      (level),
      .seed       (seed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rnd_m <= rst ? 0 : ((rnd_m == BASE - 1) ? 0 : rnd_m + 1);
   end

   // Step scoreboard: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (step !== 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL step_unexpected: got step at cycle %0d, required none", cyc);
         end else if (exp_q[0] != cyc) begin
            errors++;
            $display("FAIL step_time: got step at cycle %0d, required cycle %0d", cyc, exp_q[0]);
            if (cyc > exp_q[0])
               void'(exp_q.pop_front());
         end else begin
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic p, input logic f, input logic c);
      start = s;
      pause = p;
      food_eaten = f;
      collision = c;
      @(negedge clk);
      start = 1'b0;
      pause = 1'b0;
      food_eaten = 1'b0;
      collision = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int c0, r, s0, t0, u0, c1, c2, exp_seed;

      for (int k = 0; k < 11; k++)
         tbl[k] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, ((7 + k) > 15) ? 15 : 7 + k, 3, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 15, 3, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 15, 3, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 15, 3, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b1};

      rst = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      food_eaten = 1'b0;
      collision = 1'b0;
      idle(3);
      chk("rst_state", state, 0);
      chk("rst_step", step, 0);
      chk("rst_score", score, 0);
      chk("rst_level", level, 0);
      chk("rst_seed", seed, 0);
      rst = 1'b0;

      idle(30);
      chk("idle_state", state, 0);
      chk("idle_score", score, 0);
      chk("idle_level", level, 0);
      chk("idle_seed", seed, 0);

      exp_seed = rnd_m;
      drive(1, 0, 0, 0);
      c0 = cyc;
      chk("start_state", state, 1);
      chk("start_seed", seed, exp_seed);
      exp_q.push_back(c0 + 10);
      exp_q.push_back(c0 + 20);
      exp_q.push_back(c0 + 30);
      idle(33);
      chk("run_steps_seen", exp_q.size(), 0);

      drive(0, 1, 0, 0);
      chk("pause_state", state, 2);
      idle(50);
      chk("pause_hold_state", state, 2);
      drive(0, 1, 0, 0);
      r = cyc;
      chk("resume_state", state, 1);
      exp_q.push_back(r + 6);

      idle(6);
      s0 = cyc;
      drive(0, 0, 1, 0);
      drive(0, 0, 1, 0);
      chk("resume_step_seen", exp_q.size(), 0);
      chk("food2_score", score, 2);
      chk("food2_level", level, 1);
      exp_q.push_back(s0 + 8);
      exp_q.push_back(s0 + 16);

      idle(14);
      t0 = cyc;
      repeat (4) drive(0, 0, 1, 0);
      chk("lvl1_steps_seen", exp_q.size(), 0);
      chk("food6_score", score, 6);
      chk("food6_level", level, 3);
      exp_q.push_back(t0 + 5);
      exp_q.push_back(t0 + 9);
      exp_q.push_back(t0 + 13);

      idle(9);
      u0 = cyc;
      exp_q.push_back(u0 + 4);
      exp_q.push_back(u0 + 8);
      exp_seed = 0;
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].sd)
            exp_seed = rnd_m;
         drive(tbl[i].s, tbl[i].p, tbl[i].f, tbl[i].c);
         chk($sformatf("vec%0d_state", i), state, tbl[i].st);
         chk($sformatf("vec%0d_score", i), score, tbl[i].sc);
         chk($sformatf("vec%0d_level", i), level, tbl[i].lv);
         chk($sformatf("vec%0d_seed", i), seed, exp_seed);
      end
      chk("fast_steps_seen", exp_q.size(), 0);

      c1 = cyc;
      repeat (3) drive(0, 0, 1, 0);
      chk("pre_rst_score", score, 3);
      chk("pre_rst_level", level, 1);
      chk("pre_rst_cycle", cyc - c1, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_state", state, 0);
      chk("mid_rst_step", step, 0);
      chk("mid_rst_score", score, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_seed", seed, 0);
      rst = 1'b0;

      idle(2);
      exp_seed = rnd_m;
      drive(1, 0, 0, 0);
      c2 = cyc;
      chk("restart_state", state, 1);
      chk("restart_seed", seed, exp_seed);
      exp_q.push_back(c2 + 10);
      idle(11);
      chk("restart_step_seen", exp_q.size(), 0);
      chk("restart_run_state", state, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
